// File: rtl/pixie_pkg.sv
// Shared constants and types for the Pixie display path (DMA front end and
// video back end).
package pixie_pkg;

    localparam int FB_BYTES_PER_LINE = 8;
    localparam int FB_LINES          = 128;
    localparam int FB_ADDR_W         = 10;

    localparam int DEF_H_ACTIVE = 256;
    localparam int DEF_H_SCALE  = 4;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 32;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 256;
    localparam int DEF_V_SCALE  = 2;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 19;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
        logic first;
    } raster_flags_t;

    localparam raster_flags_t FLAGS_RESET = '{hsync: 1'b0, vsync: 1'b0,
                                              hblank: 1'b1, vblank: 1'b1,
                                              first: 1'b0};

endpackage

// File: rtl/pixie_raster_timing.sv
// Raster position counters with sync/blank/active decode. Also exposes the
// next-state counter values so a consumer can register lookahead addresses.
module pixie_raster_timing
    import pixie_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HC_W     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VC_W     = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce_pix,
    output logic [HC_W-1:0] hc,
    output logic [HC_W-1:0] hc_nxt,
    output logic [VC_W-1:0] vc,
    output logic [VC_W-1:0] vc_nxt,
    output logic            active,
    output logic            hsync,
    output logic            vsync,
    output logic            hblank,
    output logic            vblank,
    output logic            first
);

    localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [HC_W-1:0] H_ACT    = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_BEGIN = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [VC_W-1:0] V_ACT    = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_BEGIN = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC);

    always_comb begin
        hc_nxt = hc;
        vc_nxt = vc;
        if (ce_pix) begin
            if (hc == H_LAST) begin
                hc_nxt = '0;
                vc_nxt = (vc == V_LAST) ? '0 : vc + 1'b1;
            end else begin
                hc_nxt = hc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else begin
            hc <= hc_nxt;
            vc <= vc_nxt;
        end
    end

    assign hblank = (hc >= H_ACT);
    assign vblank = (vc >= V_ACT);
    assign active = !hblank && !vblank;
    assign hsync  = (hc >= HS_BEGIN) && (hc < HS_END);
    assign vsync  = (vc >= VS_BEGIN) && (vc < VS_END);
    assign first  = (hc == '0) && (vc == '0);

endmodule

// File: rtl/pixie_video_back_end.sv
// Pixie scan-out: reads the 1bpp frame buffer and emits a scaled monochrome
// pixel stream with sync/blank aligned two pixel ticks behind the counters.
module pixie_video_back_end
    import pixie_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_SCALE  = DEF_H_SCALE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_SCALE  = DEF_V_SCALE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       disp_en,
    output logic [9:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       video,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic       frame_start
);

    localparam int HC_W    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VC_W    = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int COL_W   = $clog2(FB_BYTES_PER_LINE);
    localparam int ROW_W   = $clog2(FB_LINES);
    localparam int BYTE_SH = $clog2(8 * H_SCALE);
    localparam int ROW_SH  = $clog2(V_SCALE);

    logic [HC_W-1:0] hc, hc_nxt;
    logic [VC_W-1:0] vc, vc_nxt;
    logic            active0, byte_start, pix_step;
    logic            active1;
    raster_flags_t   flags0, flags1, flags2;
    logic [7:0]      shift;

    pixie_raster_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HC_W(HC_W), .VC_W(VC_W)
    ) u_timing (
        .clk    (clk),
        .reset  (reset),
        .ce_pix (ce_pix),
        .hc     (hc),
        .hc_nxt (hc_nxt),
        .vc     (vc),
        .vc_nxt (vc_nxt),
        .active (active0),
        .hsync  (flags0.hsync),
        .vsync  (flags0.vsync),
        .hblank (flags0.hblank),
        .vblank (flags0.vblank),
        .first  (flags0.first)
    );

    assign byte_start = (hc & HC_W'(8 * H_SCALE - 1)) == '0;
    assign pix_step   = (hc & HC_W'(H_SCALE - 1)) == '0;

    // rd_addr is registered from the next counter value, so during any tick
    // interval it already names the byte for the current position and the
    // RAM has the whole interval to return it before the shift register loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr <= '0;
            shift   <= '0;
            active1 <= 1'b0;
            flags1  <= FLAGS_RESET;
            flags2  <= FLAGS_RESET;
            video   <= 1'b0;
        end else if (ce_pix) begin
            rd_addr <= {ROW_W'(vc_nxt >> ROW_SH), COL_W'(hc_nxt >> BYTE_SH)};
            if (byte_start) begin
                shift <= rd_data;
            end else if (pix_step) begin
                shift <= {shift[6:0], 1'b0};
            end
            active1 <= active0;
            flags1  <= flags0;
            flags2  <= flags1;
            video   <= shift[7] & active1 & disp_en;
        end
    end

    assign hsync  = flags2.hsync;
    assign vsync  = flags2.vsync;
    assign hblank = flags2.hblank;
    assign vblank = flags2.vblank;
    // Gated by ce_pix so the pulse lasts one clk however sparse the ticks are.
    assign frame_start = flags2.first & ce_pix & ~reset;

endmodule

// File: tb/tb_pixie_video_back_end.sv
// Directed bench for pixie_video_back_end: a reference raster model checks
// every output line, frame_start per tick, and timing/boundary counts.
module tb_pixie_video_back_end;

    localparam int HT  = 352;
    localparam int VA  = 16;
    localparam int VFP = 2;
    localparam int VS  = 3;
    localparam int VBP = 3;
    localparam int VT  = VA + VFP + VS + VBP;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce_pix = 1'b0;
    logic       disp_en = 1'b1;
    logic [9:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic       video, hsync, vsync, hblank, vblank, frame_start;

    logic [7:0] mem [1024];
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rd_data <= mem[rd_addr];

    pixie_video_back_end #(
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .disp_en(disp_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .video(video),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .frame_start(frame_start)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ch, cv, ah, av, bh, bv;
    bit a_ok, b_ok, b_disp;
    int tick_no, fs_tick, fs_cnt, fs_last, fs_period;
    int cnt_hs, cnt_hb, cnt_vs, cnt_lit;
    int disp_lo = -1;
    int disp_hi = -1;
    bit addr_moved;
    logic [351:0] obs_ln [5];
    logic [351:0] exp_ln [5];
    string nm [5] = '{"video", "hsync", "vsync", "hblank", "vblank"};

    task automatic cmp(input string tag, input logic [351:0] obs, input logic [351:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {video, hsync, vsync, hblank, vblank, frame_start} for output position (h, v)
    function automatic logic [5:0] expect_out(int h, int v, bit ok, bit d);
        logic [7:0] b;
        logic       act;
        if (!ok) return 6'b000110;
        act = (h < 256) && (v < VA);
        b = act ? mem[(v / 2) * 8 + h / 32] : 8'h00;
        return {act & b[7 - (h / 4) % 8] & d,
                (h >= 272) && (h < 304),
                (v >= VA + VFP) && (v < VA + VFP + VS),
                h >= 256, v >= VA, (h == 0) && (v == 0)};
    endfunction

    task automatic clear_stats();
        cnt_hs = 0; cnt_hb = 0; cnt_vs = 0; cnt_lit = 0;
    endtask

    task automatic tick(input int gap);
        logic [5:0] e;
        logic [9:0] held;
        held = rd_addr;
        for (int i = 0; i < gap; i++) begin
            ce_pix = 1'b0;
            @(posedge clk); #1;
            if (rd_addr !== held) addr_moved = 1'b1;
        end
        ce_pix = 1'b1;
        tick_no++;
        if (disp_lo >= 0) disp_en = !(a_ok && av >= disp_lo && av <= disp_hi);
        #3;
        e = expect_out(bh, bv, b_ok, b_disp);
        cmp("frame_start", 352'(frame_start), 352'(e[0]));
        if (frame_start === 1'b1) begin
            if (fs_cnt > 0) fs_period = cyc - fs_last;
            fs_last = cyc;
            fs_cnt++;
            fs_tick = tick_no;
        end
        @(posedge clk); #1;
        ce_pix = 1'b0;
        bh = ah; bv = av; b_ok = a_ok; b_disp = disp_en;
        ah = ch; av = cv; a_ok = 1'b1;
        ch++;
        if (ch == HT) begin
            ch = 0;
            cv = (cv == VT - 1) ? 0 : cv + 1;
        end
        e = expect_out(bh, bv, b_ok, b_disp);
        if (!b_ok) begin
            cmp("pre_output", 352'({video, hsync, vsync, hblank, vblank}), 352'(e[5:1]));
        end else begin
            obs_ln[0][bh] = video;  exp_ln[0][bh] = e[5];
            obs_ln[1][bh] = hsync;  exp_ln[1][bh] = e[4];
            obs_ln[2][bh] = vsync;  exp_ln[2][bh] = e[3];
            obs_ln[3][bh] = hblank; exp_ln[3][bh] = e[2];
            obs_ln[4][bh] = vblank; exp_ln[4][bh] = e[1];
            cnt_hs += int'(hsync); cnt_hb += int'(hblank);
            cnt_vs += int'(vsync); cnt_lit += int'(video);
            if (bh == HT - 1) begin
                for (int k = 0; k < 5; k++)
                    cmp($sformatf("line%0d_%s", bv, nm[k]), obs_ln[k], exp_ln[k]);
            end
        end
    endtask

    // ce_pix is held high during reset so reset priority is exercised too.
    task automatic do_reset(input int clks);
        reset = 1'b1;
        ce_pix = 1'b1;
        repeat (clks) @(posedge clk);
        #1;
        cmp("reset_outputs", 352'({video, hsync, vsync, hblank, vblank, frame_start}), 352'(6'b000110));
        cmp("reset_rd_addr", 352'(rd_addr), 352'(0));
        reset = 1'b0;
        ce_pix = 1'b0;
        ch = 0; cv = 0; a_ok = 1'b0; b_ok = 1'b0;
        tick_no = 0; fs_tick = 0; fs_cnt = 0; fs_period = 0;
        for (int k = 0; k < 5; k++) begin
            obs_ln[k] = '0;
            exp_ln[k] = '0;
        end
    endtask

    initial begin
        // Checkerboard 0xAA, ce_pix every clk, two frames.
        for (int i = 0; i < 1024; i++) mem[i] = 8'hAA;
        do_reset(3);
        repeat (2) tick(0);
        clear_stats();
        repeat (HT * VT) tick(0);
        cmp("hsync_ticks_per_frame", 352'(cnt_hs), 352'(VT * 32));
        cmp("hblank_ticks_per_frame", 352'(cnt_hb), 352'(VT * 96));
        cmp("vsync_ticks_per_frame", 352'(cnt_vs), 352'(3 * HT));
        cmp("checker_lit_count", 352'(cnt_lit), 352'(256 * VA / 2));
        repeat (HT * VT - 2) tick(0);
        cmp("frame_start_count", 352'(fs_cnt), 352'(2));
        cmp("frame_start_period", 352'(fs_period), 352'(HT * VT));

        // Single byte at the last row/column of this frame size.
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[63] = 8'h81;
        do_reset(2);
        repeat (2) tick(0);
        clear_stats();
        repeat (HT * VT) tick(0);
        cmp("single_byte_lit_count", 352'(cnt_lit), 352'(16));

        // Sparse, jittered ce_pix over random RAM contents.
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
        do_reset(2);
        addr_moved = 1'b0;
        repeat (HT * VT + 4) tick($urandom_range(1, 3));
        cmp("rd_addr_stable_between_ticks", 352'(addr_moved), 352'(0));

        // Reset mid-frame at hc=100, vc=10.
        do_reset(2);
        repeat (10 * HT + 100) tick(0);
        cmp("model_at_reset_point", 352'({ch[15:0], cv[15:0]}), 352'({16'd100, 16'd10}));
        do_reset(2);
        repeat (HT + 2) tick(0);
        cmp("frame_start_tick_after_reset", 352'(fs_tick), 352'(3));

        // disp_en low for output lines 4..7 with an all-lit RAM.
        for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
        do_reset(2);
        disp_lo = 4;
        disp_hi = 7;
        repeat (2) tick(0);
        clear_stats();
        repeat (HT * VT) tick(0);
        cmp("disp_en_lit_count", 352'(cnt_lit), 352'(256 * (VA - 4)));
        disp_lo = -1;
        disp_en = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
